dcache_miss_handler: RTL and testbench
======================================

Name: dcache_miss_handler

Overview:
- Services data-cache misses for the OoO core's load/store unit, on the far side of the cache's miss interface.
- Accepts miss records (optype, address, dest reg, pc, store data) into an in-order queue.
- Issues each record to backing memory over a req/gnt/rvalid handshake.
- Loads: returns result to writeback and refills the cache word. Stores: written through to memory.

Parameters:
- DEPTH, 4: miss queue entries (power of 2, ≥2).
- IDX_LSB, 2: lowest address bit of the cache index field, which is addr[12:2].
- TAG_LSB, 13: lowest address bit of the tag; tag = addr[31:13].

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- miss_valid  in  1  miss record present.
- miss_optype  in  4  LB=7, LW=8, SB=9, SW=10.
- miss_addr  in  32  byte address.
- miss_reg  in  6  destination physical register (loads).
- miss_pc  in  32  instruction pc.
- miss_wdata  in  32  store data.
- miss_ready  out  1  queue can accept; equals !full.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b0}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- resp_valid  out  1  load result pulse.
- resp_reg  out  6  destination register.
- resp_pc  out  32  pc of load.
- resp_data  out  32  LB: {24'b0, byte}; LW: word.
- fill_en  out  1  cache refill pulse.
- fill_addr  out  32  word address of refill; cache index/tag derive from it.
- fill_data  out  32  full refilled word.

Behaviour:
- Reset (async, any state): queue emptied, state IDLE. All outputs 0, except miss_ready = 1 once the queue is empty.
- Enqueue: occurs when miss_valid && miss_ready at the clock edge.
  - Optypes other than 7/8/9/10 are consumed and discarded (no queue write).
  - Push while full cannot happen, since ready is low.
  - A push and a pop in the same cycle are both honoured and count is unchanged.
- Strictly in order: a store ahead of a load to the same word completes first. No forwarding.
- IDLE: if queue non-empty, load the head into the output regs and go to REQ the next cycle.
- REQ: mem_req=1, with mem_addr/mem_we/mem_be/mem_wdata held stable until mem_gnt.
  - On gnt, a store pops the head and goes to IDLE.
  - On gnt, a load goes to WAIT. The head is not yet popped.
- mem_be values:
  - LW/SW: 4'hF.
  - SB: 1 << addr[1:0], with wdata = {4{miss_wdata[7:0]}}.
  - LB: 4'hF (the full word is read for refill).
- WAIT: mem_req=0. On mem_rvalid, capture rdata and go to RESP. Memory guarantees rvalid ≥1 cycle after gnt; rvalid in any other state is ignored.
- RESP (1 cycle): resp_valid=1 and fill_en=1 together, with fill_data = rdata. Pop head, then IDLE.
  - LB byte select: rdata[8*addr[1:0] +: 8].
- Latency: minimum enqueue→resp_valid = 4 cycles with gnt in the first REQ cycle and rvalid one cycle later (IDLE, REQ, WAIT, RESP).
- resp_valid/fill_en/mem_req are 0 in all states not listed. Data outputs hold their last values.
- Reset mid-transaction abandons the in-flight access. A late rvalid after reset lands in IDLE and is ignored.

Decomposition:
- Shared package dcache_pkg: optype constants LB/LW/SB/SW, TAG_LSB, IDX_LSB, and the state encoding {IDLE, REQ, WAIT, RESP}.
- Sub-module miss_fifo: parameterised synchronous FIFO (width 6+4+32+32+32 = 106), async active-low reset, push/pop/full/empty flags.
- The FSM and memory/response muxing stay in the top module.

Test Plan:
- LW addr 0x0000_2004, reg 5, pc 0x40; gnt first cycle, rvalid rdata 0xDEADBEEF next cycle.
  -> resp_valid on cycle 4 with reg 5, data 0xDEADBEEF, pc 0x40; fill_en with fill_addr 0x2004, fill_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x11223344.
  -> resp_data 0x00000011; fill_data 0x11223344; mem_be F.
- SB addr 0x202, data 0xAB.
  -> mem_we=1, mem_be 4'b0100, mem_wdata 0xABABABAB, mem_addr 0x200; no resp_valid, no fill_en.
- Push 5 misses back-to-back with gnt held low.
  -> miss_ready falls after the 4th; the 5th is held. Releasing gnt drains all 5 in push order.
- SW 0x300 = 0x55, then LW 0x300.
  -> the write is granted before the read request appears; load returns memory's value.
- Assert rstn low while in WAIT, then pulse rvalid.
  -> all outputs 0, no resp_valid/fill_en; miss_ready=1 after reset.

Source files
------------

// File: rtl/dcache_miss_handler_pkg.sv
// dcache_pkg: shared definitions for the data-cache miss handler.
//   - optype codes LB/LW/SB/SW as carried on the miss interface
//   - cache address field positions (index addr[12:2], tag addr[31:13])
//   - FSM state encoding and the packed miss record stored in the queue
package dcache_pkg;

    localparam logic [3:0] LB = 4'd7;
    localparam logic [3:0] LW = 4'd8;
    localparam logic [3:0] SB = 4'd9;
    localparam logic [3:0] SW = 4'd10;

    localparam int IDX_LSB = 2;
    localparam int TAG_LSB = 13;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // 6 + 4 + 32 + 32 + 32 = 106 bits
    typedef struct packed {
        logic [5:0]  rd;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] wdata;
    } miss_t;

    localparam int MISS_W = $bits(miss_t);

    function automatic logic op_valid(input logic [3:0] op);
        return (op == LB) || (op == LW) || (op == SB) || (op == SW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == SB) || (op == SW);
    endfunction

    // Byte loads still fetch the whole word so the cache line word can be refilled.
    function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] off);
        return (op == SB) ? (4'b0001 << off) : 4'hF;
    endfunction

endpackage

// File: rtl/dcache_miss_handler_if.sv
// Miss-handler bus bundle: miss request in, memory req/gnt/rvalid port,
// load response and cache refill outputs.
//   slave  : handler view (miss_* / mem_gnt / mem_rvalid / mem_rdata in)
//   master : environment view (core + memory side)
interface dcache_miss_handler_if;
    logic        miss_valid;
    logic [3:0]  miss_optype;
    logic [31:0] miss_addr;
    logic [5:0]  miss_reg;
    logic [31:0] miss_pc;
    logic [31:0] miss_wdata;
    logic        miss_ready;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        resp_valid;
    logic [5:0]  resp_reg;
    logic [31:0] resp_pc;
    logic [31:0] resp_data;

    logic        fill_en;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;

    modport slave (
        input  miss_valid, miss_optype, miss_addr, miss_reg, miss_pc, miss_wdata,
        output miss_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output resp_valid, resp_reg, resp_pc, resp_data,
        output fill_en, fill_addr, fill_data
    );

    modport master (
        output miss_valid, miss_optype, miss_addr, miss_reg, miss_pc, miss_wdata,
        input  miss_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  resp_valid, resp_reg, resp_pc, resp_data,
        input  fill_en, fill_addr, fill_data
    );
endinterface

// File: rtl/dcache_miss_handler_fifo.sv
// miss_fifo: synchronous FIFO holding miss records in arrival order.
//   clk, rstn      clock, async active-low reset (empties the queue)
//   push, din      write a record (ignored when full)
//   pop, dout      drop the head (ignored when empty); dout shows the head
//   full, empty    occupancy flags
module miss_fifo #(
    parameter int WIDTH = 106,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dcache_miss_handler.sv
// dcache_miss_handler: queues data-cache misses and services them in order
// against backing memory. Stores are written through; loads return a
// writeback result and refill the cache word in the same cycle.
//   clk, rstn  clock, async active-low reset
//   mh         miss / memory / response / refill bundle (slave view)
module dcache_miss_handler
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    dcache_miss_handler_if.slave mh
);
    miss_t  in_rec, head;
    logic   full, empty, push, pop;
    state_t state;

    // Request context kept for the response phase (fifo head is still valid
    // during WAIT, but latching keeps the response path off the fifo read mux).
    logic [3:0]  cur_op;
    logic [1:0]  cur_off;
    logic [5:0]  cur_rd;
    logic [31:0] cur_pc;

    assign in_rec = '{rd: mh.miss_reg, op: mh.miss_optype, addr: mh.miss_addr,
                      pc: mh.miss_pc, wdata: mh.miss_wdata};

    // Unknown optypes are accepted (ready high) but never stored.
    assign push = mh.miss_valid && !full && op_valid(mh.miss_optype);
    // Stores retire at grant; loads retire when their response is sent.
    assign pop  = ((state == REQ) && mh.mem_gnt && mh.mem_we) || (state == RESP);
    assign mh.miss_ready = !full;

    miss_fifo #(.WIDTH(MISS_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (in_rec),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cur_op        <= '0;
            cur_off       <= '0;
            cur_rd        <= '0;
            cur_pc        <= '0;
            mh.mem_req    <= 1'b0;
            mh.mem_we     <= 1'b0;
            mh.mem_addr   <= '0;
            mh.mem_be     <= '0;
            mh.mem_wdata  <= '0;
            mh.resp_valid <= 1'b0;
            mh.resp_reg   <= '0;
            mh.resp_pc    <= '0;
            mh.resp_data  <= '0;
            mh.fill_en    <= 1'b0;
            mh.fill_addr  <= '0;
            mh.fill_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        mh.mem_req   <= 1'b1;
                        mh.mem_we    <= op_is_store(head.op);
                        mh.mem_addr  <= {head.addr[31:2], 2'b00};
                        mh.mem_be    <= byte_en(head.op, head.addr[1:0]);
                        mh.mem_wdata <= (head.op == SB) ? {4{head.wdata[7:0]}} : head.wdata;
                        cur_op       <= head.op;
                        cur_off      <= head.addr[1:0];
                        cur_rd       <= head.rd;
                        cur_pc       <= head.pc;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (mh.mem_gnt) begin
                        mh.mem_req <= 1'b0;
                        state      <= mh.mem_we ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mh.mem_rvalid) begin
                        mh.resp_valid <= 1'b1;
                        mh.fill_en    <= 1'b1;
                        mh.resp_reg   <= cur_rd;
                        mh.resp_pc    <= cur_pc;
                        mh.resp_data  <= (cur_op == LB) ?
                                         {24'b0, mh.mem_rdata[{cur_off, 3'b000} +: 8]} :
                                         mh.mem_rdata;
                        mh.fill_addr  <= mh.mem_addr;
                        mh.fill_data  <= mh.mem_rdata;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    mh.resp_valid <= 1'b0;
                    mh.fill_en    <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_miss_handler.sv
module tb_dcache_miss_handler;
    import dcache_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dcache_miss_handler_if bus();

    dcache_miss_handler #(.DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .mh   (bus)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [5:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] faddr;
        logic [31:0] fdata;
        logic        fen;
    } resp_t;

    // stimulus + expected memory request + expected load result
    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic [31:0] fdata;
    } vec_t;

    int tests = 0;
    int fails = 0;

    req_t  got_req[$],  exp_req[$];
    resp_t got_resp[$], exp_resp[$];
    int    greq_p  = 0;
    int    gresp_p = 0;

    logic gnt_en   = 1'b1;
    logic rv_en    = 1'b1;
    logic force_rv = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: grants in the first REQ cycle, read data one cycle later.
    // Also records every granted request and every response pulse.
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (!rstn) pend = 1'b0;
            if (force_rv) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hCAFEF00D;
            end else if (pend && rv_en) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rd_mem(pend_addr);
                pend = 1'b0;
            end
            bus.mem_gnt = 1'b0;
            if (rstn && bus.mem_req && gnt_en) begin
                bus.mem_gnt = 1'b1;
                got_req.push_back('{we: bus.mem_we, be: bus.mem_be,
                                    addr: bus.mem_addr, wdata: bus.mem_wdata});
                if (bus.mem_we) begin
                    logic [31:0] w;
                    w = rd_mem(bus.mem_addr);
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                    mem[bus.mem_addr] = w;
                end else begin
                    pend      = 1'b1;
                    pend_addr = bus.mem_addr;
                end
            end
            if (bus.resp_valid)
                got_resp.push_back('{rd: bus.resp_reg, pc: bus.resp_pc, data: bus.resp_data,
                                     faddr: bus.fill_addr, fdata: bus.fill_data,
                                     fen: bus.fill_en});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic is_load(input logic [3:0] op);
        return (op == LB) || (op == LW);
    endfunction

    task automatic push_exp(input vec_t v);
        if (v.op == LB || v.op == LW || v.op == SB || v.op == SW) begin
            exp_req.push_back('{we: (v.op == SB || v.op == SW), be: v.be,
                                addr: {v.addr[31:2], 2'b00}, wdata: v.mwdata});
            if (is_load(v.op))
                exp_resp.push_back('{rd: v.rd, pc: v.pc, data: v.rdata,
                                     faddr: {v.addr[31:2], 2'b00}, fdata: v.fdata, fen: 1'b1});
        end
    endtask

    task automatic drive(input vec_t v);
        bus.miss_valid  = 1'b1;
        bus.miss_optype = v.op;
        bus.miss_addr   = v.addr;
        bus.miss_reg    = v.rd;
        bus.miss_pc     = v.pc;
        bus.miss_wdata  = v.wdata;
    endtask

    // one-cycle push; returns just after the accepting edge
    task automatic send(input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        bus.miss_valid = 1'b0;
    endtask

    task automatic check_q(input string tag);
        int cyc = 0;
        while (((got_req.size() - greq_p) < exp_req.size() ||
                (got_resp.size() - gresp_p) < exp_resp.size()) && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        repeat (3) begin @(negedge clk); #1; end
        chk({tag, "_nreq"},  64'(got_req.size() - greq_p),   64'(exp_req.size()));
        chk({tag, "_nresp"}, 64'(got_resp.size() - gresp_p), 64'(exp_resp.size()));
        while (exp_req.size() > 0 && greq_p < got_req.size()) begin
            req_t e, g;
            e = exp_req.pop_front();
            g = got_req[greq_p++];
            chk({tag, "_we"},   64'(g.we),   64'(e.we));
            chk({tag, "_be"},   64'(g.be),   64'(e.be));
            chk({tag, "_addr"}, 64'(g.addr), 64'(e.addr));
            if (e.we) chk({tag, "_wdata"}, 64'(g.wdata), 64'(e.wdata));
        end
        while (exp_resp.size() > 0 && gresp_p < got_resp.size()) begin
            resp_t e, g;
            e = exp_resp.pop_front();
            g = got_resp[gresp_p++];
            chk({tag, "_reg"},   64'(g.rd),    64'(e.rd));
            chk({tag, "_pc"},    64'(g.pc),    64'(e.pc));
            chk({tag, "_data"},  64'(g.data),  64'(e.data));
            chk({tag, "_faddr"}, 64'(g.faddr), 64'(e.faddr));
            chk({tag, "_fdata"}, 64'(g.fdata), 64'(e.fdata));
            chk({tag, "_fen"},   64'(g.fen),   64'(e.fen));
        end
        exp_req.delete();
        exp_resp.delete();
        greq_p  = got_req.size();
        gresp_p = got_resp.size();
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ready"}, 64'(bus.miss_ready), 64'd1);
        chk({tag, "_ctl"},   64'({bus.mem_req, bus.mem_we, bus.mem_be, bus.resp_valid,
                                  bus.fill_en, bus.resp_reg}), 64'd0);
        chk({tag, "_mem"},   {bus.mem_addr, bus.mem_wdata}, 64'd0);
        chk({tag, "_resp"},  {bus.resp_pc, bus.resp_data},  64'd0);
        chk({tag, "_fill"},  {bus.fill_addr, bus.fill_data}, 64'd0);
    endtask

    vec_t vt[8];
    vec_t bt[5];

    initial begin
        int lat;
        int cyc;
        logic seen;

        bus.miss_valid  = 1'b0;
        bus.miss_optype = '0;
        bus.miss_addr   = '0;
        bus.miss_reg    = '0;
        bus.miss_pc     = '0;
        bus.miss_wdata  = '0;

        mem[32'h2004] = 32'hDEADBEEF;
        mem[32'h0100] = 32'h11223344;

        //         op     addr          rd     pc            wdata          be     mwdata         rdata          fdata
        vt[0] = '{LW,   32'h0000_2004, 6'd5,  32'h40, 32'h0,         4'hF, 32'h0,         32'hDEADBEEF, 32'hDEADBEEF};
        vt[1] = '{LB,   32'h0000_0103, 6'd7,  32'h44, 32'h0,         4'hF, 32'h0,         32'h00000011, 32'h11223344};
        vt[2] = '{SB,   32'h0000_0202, 6'd0,  32'h48, 32'hFFFF_FFAB, 4'h4, 32'hABABABAB,  32'h0,        32'h0};
        vt[3] = '{SW,   32'h0000_0300, 6'd0,  32'h4C, 32'h55,        4'hF, 32'h55,        32'h0,        32'h0};
        vt[4] = '{LW,   32'h0000_0300, 6'd9,  32'h50, 32'h0,         4'hF, 32'h0,         32'h55,       32'h55};
        vt[5] = '{LB,   32'h0000_0202, 6'd10, 32'h54, 32'h0,         4'hF, 32'h0,         32'hAB,       32'h00AB0000};
        vt[6] = '{4'd3, 32'h0000_0500, 6'd11, 32'h58, 32'h0,         4'hF, 32'h0,         32'h0,        32'h0};
        vt[7] = '{LB,   32'h0000_0100, 6'd12, 32'h5C, 32'h0,         4'hF, 32'h0,         32'h44,       32'h11223344};

        bt[0] = '{SW, 32'h400, 6'd0, 32'h100, 32'h1,  4'hF, 32'h1,       32'h0,    32'h0};
        bt[1] = '{LW, 32'h400, 6'd1, 32'h104, 32'h0,  4'hF, 32'h0,       32'h1,    32'h1};
        bt[2] = '{SB, 32'h401, 6'd0, 32'h108, 32'h22, 4'h2, 32'h22222222, 32'h0,   32'h0};
        bt[3] = '{LB, 32'h401, 6'd2, 32'h10C, 32'h0,  4'hF, 32'h0,       32'h22,   32'h2201};
        bt[4] = '{LW, 32'h400, 6'd3, 32'h110, 32'h0,  4'hF, 32'h0,       32'h2201, 32'h2201};

        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rstn = 1'b1;

        // single transactions; loads must respond on the 4th cycle after enqueue
        for (int i = 0; i < 8; i++) begin
            push_exp(vt[i]);
            send(vt[i]);
            if (is_load(vt[i].op)) begin
                lat = 0;
                while (!bus.resp_valid && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            end
            check_q($sformatf("v%0d", i));
        end

        // back-to-back with grant withheld: queue fills at 4, 5th is held
        gnt_en = 1'b0;
        for (int k = 0; k < 5; k++) push_exp(bt[k]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(bt[k]);
            chk($sformatf("bb_ready%0d", k), 64'(bus.miss_ready), 64'd1);
        end
        @(negedge clk);
        drive(bt[4]);
        chk("bb_full", 64'(bus.miss_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("bb_held", 64'(bus.miss_ready), 64'd0);
        chk("bb_nogrant", 64'(got_req.size() - greq_p), 64'd0);
        gnt_en = 1'b1;
        cyc = 0;
        while (!bus.miss_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("bb_ready_rise", 64'(bus.miss_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.miss_valid = 1'b0;
        check_q("bb");

        // reset while waiting for read data, then a stray rvalid
        rv_en = 1'b0;
        send('{LW, 32'h2004, 6'd20, 32'h80, 32'h0, 4'hF, 32'h0, 32'h0, 32'h0});
        cyc = 0;
        while (got_req.size() == greq_p && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("rw_granted", 64'(got_req.size() - greq_p), 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_outs("rw_reset");
        greq_p = got_req.size();
        @(posedge clk); #1;
        rstn     = 1'b1;
        force_rv = 1'b1;
        @(posedge clk); #1;
        force_rv = 1'b0;
        rv_en    = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.resp_valid | bus.fill_en | bus.mem_req;
        end
        chk("rw_late_rvalid", 64'(seen), 64'd0);
        chk("rw_nresp", 64'(got_resp.size() - gresp_p), 64'd0);
        chk("rw_ready", 64'(bus.miss_ready), 64'd1);

        // handler still works after the abandoned access
        push_exp(vt[1]);
        send(vt[1]);
        check_q("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
